// File: rtl/ahb_lite_sram_slave_pkg.sv
// ahb_slv_pkg: shared AHB-Lite transfer types, response codes and slave FSM states
package ahb_slv_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
    typedef enum logic [2:0] {SZ_BYTE = 3'b000, SZ_HALF = 3'b001, SZ_WORD = 3'b010, SZ_DWORD = 3'b011} hsize_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} slv_state_t;
endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if: AHB-Lite slave-side bus bundle
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY, receives HRDATA/HREADYOUT/HRESP
//   slave modport : the mirror image
interface ahb_lite_sram_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave_lane_dec.sv
// ahb_byte_lane_dec: combinational byte-strobe and alignment/size decode for one transfer
//   hsize    : AHB HSIZE
//   addr_lo  : byte-within-beat address bits
//   strb     : one bit per byte lane written by the transfer
//   misalign : address not aligned to 2**hsize
//   oversize : 2**hsize wider than the data bus
module ahb_byte_lane_dec #(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int LSB        = $clog2(NB)
) (
    input  logic [2:0]     hsize,
    input  logic [LSB-1:0] addr_lo,
    output logic [NB-1:0]  strb,
    output logic           misalign,
    output logic           oversize
);
    logic [LSB-1:0] mask;
    for (genvar i = 0; i < LSB; i++) begin : g_mask
        assign mask[i] = 3'(i) < hsize;
    end
    // a lane is enabled when it falls in the same 2**hsize-byte block as the address
    for (genvar j = 0; j < NB; j++) begin : g_strb
        assign strb[j] = (LSB'(j) >> hsize) == (addr_lo >> hsize);
    end
    assign misalign = |(addr_lo & mask);
    assign oversize = hsize > 3'(LSB);
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite SRAM slave with byte strobes, wait states, read-only window and two-cycle ERROR
//   HCLK      : clock, everything on posedge
//   HRESET    : asynchronous active-high reset
//   bus       : ahb_lite_sram_slave_if.slave (address/control/write data in, HRDATA/HREADYOUT/HRESP out)
//   err_count : present only when AHB_SLV_ERR_CNT_EN is defined; saturating count of ERROR responses
module ahb_lite_sram_slave
    import ahb_slv_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          DATA_WIDTH  = 32,
    parameter int          WAIT_STATES = 0,
    parameter int unsigned RO_START    = 'h000,
    parameter int unsigned RO_END      = 'h00F
) (
    input  logic HCLK,
    input  logic HRESET,
`ifdef AHB_SLV_ERR_CNT_EN
    output logic [15:0] err_count,
`endif
    ahb_lite_sram_slave_if.slave bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - LSB;

    slv_state_t            state, next_state;
    logic [IW-1:0]         widx_q;
    logic                  write_q;
    logic [NB-1:0]         strb_q;
    logic [3:0]            wcnt;
    logic [DATA_WIDTH-1:0] mem [2**IW];
    logic [NB-1:0]         strb;
    logic                  misalign, oversize, err_ro, err, accept, done, free, take;

    ahb_byte_lane_dec #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .hsize    (bus.HSIZE),
        .addr_lo  (bus.HADDR[LSB-1:0]),
        .strb     (strb),
        .misalign (misalign),
        .oversize (oversize)
    );

    // window test by offset so a window starting at 0 needs no always-true compare
    assign err_ro = bus.HWRITE &&
        (ADDR_WIDTH'(bus.HADDR - ADDR_WIDTH'(RO_START)) <= ADDR_WIDTH'(RO_END - RO_START));
    assign err    = err_ro || misalign || oversize;
    assign accept = bus.HSEL && bus.HREADY && (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ);
    assign done   = state == ST_DATA && wcnt == 4'd0;
    // cycles in which the slave can take a new address phase alongside its own completion
    assign free   = state == ST_IDLE || state == ST_ERR2 || done;
    assign take   = free && accept;

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) state <= ST_IDLE;
        else state <= next_state;

    always_comb
        next_state = take ? (err ? ST_ERR1 : ST_DATA) :
                     state == ST_ERR1 ? ST_ERR2 :
                     free ? ST_IDLE : state;

    always_comb begin
        bus.HREADYOUT = state == ST_DATA ? wcnt == 4'd0 : state != ST_ERR1;
        bus.HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        bus.HRDATA    = done && !write_q ? mem[widx_q] : '0;
    end

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            widx_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wcnt    <= '0;
        end else if (take) begin
            widx_q  <= bus.HADDR[ADDR_WIDTH-1:LSB];
            write_q <= bus.HWRITE;
            strb_q  <= strb;
            wcnt    <= err ? 4'd0 : 4'(WAIT_STATES);
        end else if (state == ST_DATA && wcnt != 4'd0)
            wcnt <= wcnt - 4'd1;

    // write commits on the edge that closes the data phase; reset forces ST_IDLE so nothing commits
    always_ff @(posedge HCLK)
        if (done && write_q)
            for (int j = 0; j < NB; j++)
                if (strb_q[j]) mem[widx_q][8*j +: 8] <= bus.HWDATA[8*j +: 8];

`ifdef AHB_SLV_ERR_CNT_EN
    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) err_count <= '0;
        else if (take && err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed table-driven bench for two slave instances (0 and 3 wait states)
module tb_ahb_lite_sram_slave;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        which = 1'b0;
    logic        hsel = 1'b0;
    logic [11:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic        rdy, resp;
    logic [31:0] rdata;
    int checks = 0;
    int fails = 0;

    ahb_lite_sram_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b0 ();
    ahb_lite_sram_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b3 ();

    assign b0.HSEL = hsel & ~which;
    assign b3.HSEL = hsel & which;
    assign b0.HADDR = haddr;
    assign b3.HADDR = haddr;
    assign b0.HTRANS = htrans;
    assign b3.HTRANS = htrans;
    assign b0.HWRITE = hwrite;
    assign b3.HWRITE = hwrite;
    assign b0.HSIZE = hsize;
    assign b3.HSIZE = hsize;
    assign b0.HWDATA = hwdata;
    assign b3.HWDATA = hwdata;
    assign b0.HREADY = b0.HREADYOUT;
    assign b3.HREADY = b3.HREADYOUT;
    assign rdy   = which ? b3.HREADYOUT : b0.HREADYOUT;
    assign resp  = which ? b3.HRESP : b0.HRESP;
    assign rdata = which ? b3.HRDATA : b0.HRDATA;

`ifdef AHB_SLV_ERR_CNT_EN
    logic [15:0] ec0, ec3, ec;
    assign ec = which ? ec3 : ec0;
    ahb_lite_sram_slave #(.WAIT_STATES(0)) u0 (.HCLK(HCLK), .HRESET(HRESET), .err_count(ec0), .bus(b0));
    ahb_lite_sram_slave #(.WAIT_STATES(3)) u3 (.HCLK(HCLK), .HRESET(HRESET), .err_count(ec3), .bus(b3));
`else
    ahb_lite_sram_slave #(.WAIT_STATES(0)) u0 (.HCLK(HCLK), .HRESET(HRESET), .bus(b0));
    ahb_lite_sram_slave #(.WAIT_STATES(3)) u3 (.HCLK(HCLK), .HRESET(HRESET), .bus(b3));
`endif

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        which;
        logic        wr;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_resp;
        int          exp_waits;
        int          exp_ec;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one NONSEQ transfer; returns in the data phase's final (HREADYOUT high) cycle
    task automatic xfer(input logic w, input logic [11:0] a, input logic [2:0] s, input logic [31:0] wd,
                        output logic [31:0] rd, output logic r0, output logic rs, output int waits);
        hsel = 1'b1;
        htrans = 2'b10;
        haddr = a;
        hwrite = w;
        hsize = s;
        @(posedge HCLK);
        #1;
        hsel = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        r0 = resp;
        waits = 0;
        while (!rdy && waits < 40) begin
            waits++;
            @(posedge HCLK);
            #1;
        end
        rd = rdata;
        rs = resp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, pre;
        logic r0, rs;
        int w;
        v.push_back('{1'b0, 1'b1, 12'h100, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 0, 0});
        v.push_back('{1'b0, 1'b0, 12'h100, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 0, 0});
        v.push_back('{1'b0, 1'b1, 12'h104, 3'b010, 32'h11223344, 32'h0,        1'b0, 0, 0});
        v.push_back('{1'b0, 1'b1, 12'h105, 3'b000, 32'h0000AA00, 32'h0,        1'b0, 0, 0});
        v.push_back('{1'b0, 1'b0, 12'h104, 3'b010, 32'h0,        32'h1122AA44, 1'b0, 0, 0});
        v.push_back('{1'b0, 1'b1, 12'h101, 3'b001, 32'h0000FFFF, 32'h0,        1'b1, 1, 1});
        v.push_back('{1'b0, 1'b0, 12'h100, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1});
        v.push_back('{1'b0, 1'b1, 12'h100, 3'b011, 32'h01020304, 32'h0,        1'b1, 1, 2});
        v.push_back('{1'b0, 1'b0, 12'h100, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 0, 2});
        v.push_back('{1'b0, 1'b1, 12'h106, 3'b001, 32'h55660000, 32'h0,        1'b0, 0, 2});
        v.push_back('{1'b0, 1'b0, 12'h104, 3'b010, 32'h0,        32'h5566AA44, 1'b0, 0, 2});
        v.push_back('{1'b0, 1'b1, 12'h010, 3'b010, 32'h0F0F0F0F, 32'h0,        1'b0, 0, 2});
        v.push_back('{1'b0, 1'b0, 12'h010, 3'b010, 32'h0,        32'h0F0F0F0F, 1'b0, 0, 2});
        v.push_back('{1'b1, 1'b1, 12'h200, 3'b010, 32'h12345678, 32'h0,        1'b0, 3, 0});
        v.push_back('{1'b1, 1'b0, 12'h200, 3'b010, 32'h0,        32'h12345678, 1'b0, 3, 0});
        v.push_back('{1'b1, 1'b1, 12'h00C, 3'b010, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 1});

        #12;
        chk("reset u0 hreadyout", 32'(b0.HREADYOUT), 32'd1);
        chk("reset u0 hresp", 32'(b0.HRESP), 32'd0);
        chk("reset u0 hrdata", b0.HRDATA, 32'h0);
        chk("reset u3 hreadyout", 32'(b3.HREADYOUT), 32'd1);
        chk("reset u3 hresp", 32'(b3.HRESP), 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        foreach (v[i]) begin
            which = v[i].which;
            xfer(v[i].wr, v[i].addr, v[i].size, v[i].wdata, rd, r0, rs, w);
            chk($sformatf("v%0d resp first", i), 32'(r0), 32'(v[i].exp_resp));
            chk($sformatf("v%0d resp last", i), 32'(rs), 32'(v[i].exp_resp));
            chk($sformatf("v%0d wait cycles", i), 32'(w), 32'(v[i].exp_waits));
            if (!v[i].wr) chk($sformatf("v%0d hrdata", i), rd, v[i].exp_rdata);
`ifdef AHB_SLV_ERR_CNT_EN
            chk($sformatf("v%0d err_count", i), 32'(ec), 32'(v[i].exp_ec));
`endif
        end

        which = 1'b0;
        xfer(1'b0, 12'h008, 3'b010, 32'h0, pre, r0, rs, w);
        xfer(1'b1, 12'h008, 3'b010, 32'hA5A5A5A5, rd, r0, rs, w);
        chk("ro write resp first", 32'(r0), 32'd1);
        chk("ro write resp last", 32'(rs), 32'd1);
        chk("ro write waits", 32'(w), 32'd1);
        xfer(1'b0, 12'h008, 3'b010, 32'h0, rd, r0, rs, w);
        chk("ro readback unchanged", rd, pre);

        which = 1'b1;
        hsel = 1'b1;
        htrans = 2'b01;
        haddr = 12'h200;
        hwrite = 1'b1;
        hwdata = 32'hBADBADBA;
        @(posedge HCLK);
        #1;
        chk("busy hreadyout", 32'(rdy), 32'd1);
        chk("busy hresp", 32'(resp), 32'd0);
        htrans = 2'b00;
        @(posedge HCLK);
        #1;
        chk("idle hreadyout", 32'(rdy), 32'd1);
        chk("idle hresp", 32'(resp), 32'd0);
        hsel = 1'b0;
        xfer(1'b0, 12'h200, 3'b010, 32'h0, rd, r0, rs, w);
        chk("after busy read data", rd, 32'h12345678);
        chk("after busy read waits", 32'(w), 32'd3);

        xfer(1'b1, 12'h300, 3'b010, 32'hAAAA5555, rd, r0, rs, w);
        hsel = 1'b1;
        htrans = 2'b10;
        haddr = 12'h300;
        hwrite = 1'b1;
        hsize = 3'b010;
        @(posedge HCLK);
        #1;
        hsel = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h0BAD0BAD;
        chk("wait state 1 hreadyout", 32'(rdy), 32'd0);
        @(posedge HCLK);
        #1;
        chk("wait state 2 hreadyout", 32'(rdy), 32'd0);
        HRESET = 1'b1;
        #1;
        chk("mid reset hreadyout", 32'(rdy), 32'd1);
        chk("mid reset hresp", 32'(resp), 32'd0);
`ifdef AHB_SLV_ERR_CNT_EN
        chk("mid reset err_count", 32'(ec), 32'd0);
`endif
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        xfer(1'b0, 12'h300, 3'b010, 32'h0, rd, r0, rs, w);
        chk("post reset read old value", rd, 32'hAAAA5555);
        chk("post reset read waits", 32'(w), 32'd3);

        @(posedge HCLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- Parametrised AHB-Lite slave memory; next generation of the team's single-width slave memory.
- Adds:
  - byte/halfword/word writes via HSIZE, with byte strobes;
  - a configurable wait-state count;
  - a parametrised read-only window;
  - misalignment checking;
  - the protocol-correct two-cycle ERROR response.
- Sits behind the AHB decoder/mux: HSEL from the decoder; HREADYOUT/HRESP/HRDATA go to the slave-to-master mux.

Parameters:
- ADDR_WIDTH, 12, byte-address width; memory depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words.
- DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; legal range 0..15.
- RO_START, 'h000, first byte address of the read-only window (inclusive).
- RO_END, 'h00F, last byte address of the read-only window (inclusive).

Ports:
- HCLK  in  1  single clock; all logic rises on posedge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 000=byte, 001=half, 010=word, 011=dword.
- HWDATA  in  DATA_WIDTH  write data (data phase).
- HREADY  in  1  bus-level ready (previous transfer complete).
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESET is asynchronous and active-high.
- Reset values:
  - state = ST_IDLE, HREADYOUT = 1, HRESP = 0, HRDATA = 0;
  - registered addr/size/write and wait counter = 0;
  - memory contents are not reset.
- Address phase is accepted only when HSEL && HREADY && HTRANS[1].
  - IDLE, BUSY, or HSEL=0 with HREADY=1: no state change; zero-wait OKAY.
- Checks performed at acceptance:
  - err_ro: HWRITE && RO_START <= HADDR <= RO_END.
  - err_align: HADDR is not aligned to 2**HSIZE.
  - err_size: 2**HSIZE > DATA_WIDTH/8.
  - err = any of the three.
- FSM states:
  - ST_IDLE: HREADYOUT=1, HRESP=0.
    - Accept with err -> ST_ERR1.
    - Accept without err -> ST_DATA, wcnt <= WAIT_STATES.
  - ST_DATA: HREADYOUT = (wcnt==0), HRESP=0.
    - wcnt>0: decrement.
    - wcnt==0: transfer completes this cycle.
      - Write: mem word at addr_q is updated at the closing edge, byte lanes only per strobe, HWDATA sampled.
      - Read: HRDATA = mem[addr_q] (combinational from registered address), valid only while HREADYOUT=1; otherwise 0.
      - Same-cycle new accept -> ST_DATA or ST_ERR1; else -> ST_IDLE.
  - ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1; no memory write.
    - A new accept in this cycle is honoured as in ST_IDLE.
- Byte strobes:
  - Byte: one lane, selected by addr[lsb].
  - Halfword: two lanes.
  - Word: four lanes.
  - Dword (DATA_WIDTH=64): all lanes.
- Back-to-back write then read of the same address: the read data phase returns the newly written data.
- HADDR bits above the depth are ignored; the address wraps modulo the depth.
- Reset asserted mid-data-phase: immediate return to reset values; the in-flight write is not committed.

Optional Feature:
- Macro: AHB_SLV_ERR_CNT_EN.
- Defined:
  - Extra output err_count [15:0] increments on each ST_ERR1 entry.
  - Saturates at 16'hFFFF.
  - Cleared by HRESET.
- Undefined: no port, no counter logic.

Decomposition:
- Package ahb_slv_pkg holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ);
  - hsize_t enum;
  - HRESP_OKAY/HRESP_ERROR constants;
  - slv_state_t enum (ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2).
- One sub-module, ahb_byte_lane_dec, is natural:
  - Inputs: HSIZE, addr low bits.
  - Outputs: byte strobe vector [DATA_WIDTH/8-1:0], misalign flag, oversize flag.
  - Purely combinational.

Test Plan:
- WAIT_STATES=0: NONSEQ write 'h100 = 32'hDEADBEEF, then NONSEQ read 'h100 -> HRDATA=32'hDEADBEEF in the cycle after the read address phase; HRESP=0 throughout.
- Write 32'h11223344 to 'h104, then byte write 8'hAA to 'h105 (HSIZE=000, HWDATA=32'h0000AA00), then read 'h104 -> 32'h1122AA44.
- Write to 'h008 (read-only) -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; a subsequent read of 'h008 returns the pre-test value.
- Halfword write to 'h101 -> misalignment ERROR, two-cycle; memory unchanged. With AHB_SLV_ERR_CNT_EN, err_count goes 0 -> 1.
- WAIT_STATES=3: read 'h200 -> HREADYOUT low for exactly 3 cycles, then high with data. A BUSY then IDLE sequence gives zero-wait OKAY.
- Assert HRESET during wait state 2 of a write to 'h300 -> HREADYOUT=1 and HRESP=0 immediately; read 'h300 after reset shows the old value.
